// File: rtl/p_shfrot_pkg.sv
// Shared definitions for the multi-cycle packed shift/rotate engine:
// FSM encoding, pack-width indices and the per-width amount mask.
package p_shfrot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bit positions of the one-hot pack-width field; element width is 32 >> index.
   localparam int NUM_PW = 5;
   localparam int PW_32  = 0;
   localparam int PW_16  = 1;
   localparam int PW_8   = 2;
   localparam int PW_4   = 3;
   localparam int PW_2   = 4;

   function automatic logic pw_legal(input logic [4:0] pw);
      return $onehot(pw);
   endfunction

   // Effective amount: shamt masked to the element width, 0 for an illegal width.
   function automatic logic [4:0] shamt_mask(input logic [4:0] shamt, input logic [4:0] pw);
      logic [4:0] n;
      n = '0;
      case (pw)
         5'd1 << PW_32: n = shamt;
         5'd1 << PW_16: n = {1'b0, shamt[3:0]};
         5'd1 << PW_8:  n = {2'b0, shamt[2:0]};
         5'd1 << PW_4:  n = {3'b0, shamt[1:0]};
         5'd1 << PW_2:  n = {4'b0, shamt[0]};
         default:       n = '0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/p_shfrot_mc_if.sv
// Request/response bundle between the instruction sequencer and the
// multi-cycle shift/rotate engine.
interface p_shfrot_mc_if;
   logic        valid;
   logic [31:0] crs1;
   logic [4:0]  shamt;
   logic [4:0]  pw;
   logic        shift;
   logic        rotate;
   logic        left;
   logic        right;
   logic        ready;
   logic [31:0] result;

   modport master (
      output valid, crs1, shamt, pw, shift, rotate, left, right,
      input  ready, result
   );

   modport slave (
      input  valid, crs1, shamt, pw, shift, rotate, left, right,
      output ready, result
   );
endinterface

// File: rtl/p_shfrot_step.sv
// Combinational packed shift/rotate by one or two bit positions; no bit
// ever crosses an element boundary.
module p_shfrot_step
   import p_shfrot_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [4:0]  pw_i,
   input  logic        rotate_i,
   input  logic        left_i,
   input  logic        double_i,
   output logic [31:0] data_o
);

   logic [NUM_PW-1:0][31:0] once_w;
   logic [NUM_PW-1:0][31:0] twice_w;

   // A 2-bit step is two chained 1-bit steps, so w2 falls out as identity/zero.
   generate
      for (genvar wi = 0; wi < NUM_PW; wi++) begin : g_width
         localparam int W = 32 >> wi;
         for (genvar gi = 0; gi < 32 / W; gi++) begin : g_elem
            logic [W-1:0] e0;
            logic [W-1:0] e1;
            logic [W-1:0] e2;
            assign e0 = data_i[gi*W +: W];
            assign e1 = left_i ? {e0[W-2:0], rotate_i & e0[W-1]}
                               : {rotate_i & e0[0], e0[W-1:1]};
            assign e2 = left_i ? {e1[W-2:0], rotate_i & e1[W-1]}
                               : {rotate_i & e1[0], e1[W-1:1]};
            assign once_w[wi][gi*W +: W]  = e1;
            assign twice_w[wi][gi*W +: W] = e2;
         end
      end
   endgenerate

   always_comb begin
      data_o = data_i;
      for (int i = 0; i < NUM_PW; i++) begin
         if (pw_i[i]) begin
            data_o = double_i ? twice_w[i] : once_w[i];
         end
      end
   end

endmodule

// File: rtl/p_shfrot_mc.sv
// Multi-cycle packed shift/rotate engine for amounts 0-31.
// Build option: P_SHFROT_MC_DOUBLE_STEP_EN retires two bit positions per RUN cycle.
module p_shfrot_mc
   import p_shfrot_pkg::*;
(
   input logic          g_clk,
   input logic          g_reset,
   p_shfrot_mc_if.slave bus
);

   state_e      state_q,  state_d;
   logic [31:0] data_q,   data_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  cnt_q,    cnt_d;
   logic [4:0]  pw_q,     pw_d;
   logic        rotate_q, rotate_d;
   logic        left_q,   left_d;
   logic        legal_q,  legal_d;

   logic [31:0] step_data;
   logic        step_double;
   logic [4:0]  step_amt;

   // Direction and operation are fully decoded from left and rotate alone.
   logic unused_ok;
   assign unused_ok = &{1'b0, bus.shift, bus.right};

`ifdef P_SHFROT_MC_DOUBLE_STEP_EN
   assign step_double = (cnt_q >= 5'd2);
`else
   assign step_double = 1'b0;
`endif
   assign step_amt = step_double ? 5'd2 : 5'd1;

   p_shfrot_step u_step (
      .data_i   (data_q),
      .pw_i     (pw_q),
      .rotate_i (rotate_q),
      .left_i   (left_q),
      .double_i (step_double),
      .data_o   (step_data)
   );

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      pw_d     = pw_q;
      rotate_d = rotate_q;
      left_d   = left_q;
      legal_d  = legal_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.valid) begin
               data_d   = bus.crs1;
               cnt_d    = shamt_mask(bus.shamt, bus.pw);
               pw_d     = bus.pw;
               rotate_d = bus.rotate;
               left_d   = bus.left;
               legal_d  = pw_legal(bus.pw);
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q != 5'd0) begin
               data_d = step_data;
               cnt_d  = cnt_q - step_amt;
            end else begin
               result_d = legal_q ? data_q : 32'd0;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         pw_q     <= '0;
         rotate_q <= 1'b0;
         left_q   <= 1'b0;
         legal_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         pw_q     <= pw_d;
         rotate_q <= rotate_d;
         left_q   <= left_d;
         legal_q  <= legal_d;
      end
   end

   assign bus.ready  = (state_q == ST_DONE);
   assign bus.result = result_q;

endmodule
